// File: rtl/stream_dscr_slv.sv
// Receive-side descrambler synchroniser: acquires, verifies and tracks a remote 33-bit scrambler LFSR.
// Build option DSCR_MASTER_POLY_EN selects the master polynomial x^33+x^13+1 instead of x^33+x^20+1.
module stream_dscr_slv #(
  parameter int unsigned VERIFY_CNT = 64,
  parameter int unsigned ERR_MAX    = 4,
  parameter int unsigned WIN_LEN    = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        valid,
  input  logic        idle_ind,
  input  logic        rx_bit,
  output logic [32:0] rand_num,
  output logic        locked,
  output logic        lock_err,
  output logic [1:0]  state
);

  localparam int unsigned LFSR_W  = 33;
  localparam int unsigned FILL_W  = 6;
  localparam int unsigned MATCH_W = 8;
  localparam int unsigned ERR_W   = 4;
  localparam int unsigned WIN_W   = 16;
`ifdef DSCR_MASTER_POLY_EN
  localparam int unsigned TAP_IDX = 12;
`else
  localparam int unsigned TAP_IDX = 19;
`endif

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_VERIFY   = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   rand_num_q, rand_num_d;
  logic                locked_q, locked_d;
  logic                lock_err_q, lock_err_d;
  logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;

  logic                pred;
  logic                mismatch;
  logic                win_last;
  logic [ERR_W-1:0]    err_inc;
  logic [LFSR_W-1:0]   lfsr_adv;

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_UNLOCKED;
      rand_num_q  <= '0;
      locked_q    <= 1'b0;
      lock_err_q  <= 1'b0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      err_cnt_q   <= '0;
      win_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rand_num_q  <= rand_num_d;
      locked_q    <= locked_d;
      lock_err_q  <= lock_err_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      err_cnt_q   <= err_cnt_d;
      win_cnt_q   <= win_cnt_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    rand_num_d  = rand_num_q;
    lock_err_d  = 1'b0;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    err_cnt_d   = err_cnt_q;
    win_cnt_d   = win_cnt_q;

    pred     = rand_num_q[LFSR_W-1] ^ rand_num_q[TAP_IDX];
    mismatch = idle_ind && (pred != rx_bit);
    win_last = (win_cnt_q == WIN_W'(WIN_LEN - 1));
    err_inc  = err_cnt_q + ERR_W'(1);
    lfsr_adv = {rand_num_q[LFSR_W-2:0], pred};

    if (load) begin
      state_d     = ST_UNLOCKED;
      fill_cnt_d  = '0;
      match_cnt_d = '0;
      err_cnt_d   = '0;
      win_cnt_d   = '0;
    end else if (valid) begin
      unique case (state_q)
        ST_UNLOCKED: begin
          if (idle_ind) begin
            rand_num_d = {rand_num_q[LFSR_W-2:0], rx_bit};
            if (fill_cnt_q == FILL_W'(LFSR_W - 1)) begin
              state_d     = ST_VERIFY;
              fill_cnt_d  = '0;
              match_cnt_d = '0;
            end else begin
              fill_cnt_d = fill_cnt_q + FILL_W'(1);
            end
          end else begin
            fill_cnt_d = '0;
          end
        end

        ST_VERIFY: begin
          rand_num_d = lfsr_adv;
          if (mismatch) begin
            lock_err_d  = 1'b1;
            state_d     = ST_UNLOCKED;
            fill_cnt_d  = '0;
            match_cnt_d = '0;
          end else if (idle_ind) begin
            match_cnt_d = match_cnt_q + MATCH_W'(1);
            if (match_cnt_q == MATCH_W'(VERIFY_CNT - 1)) begin
              state_d     = ST_LOCKED;
              match_cnt_d = '0;
              err_cnt_d   = '0;
              win_cnt_d   = '0;
            end
          end
        end

        ST_LOCKED: begin
          rand_num_d = lfsr_adv;
          win_cnt_d  = win_last ? '0 : win_cnt_q + WIN_W'(1);
          if (mismatch) begin
            lock_err_d = 1'b1;
          end
          // Loss of lock outranks the window restart
          if (mismatch && (err_inc == ERR_W'(ERR_MAX))) begin
            state_d     = ST_UNLOCKED;
            fill_cnt_d  = '0;
            match_cnt_d = '0;
            err_cnt_d   = '0;
            win_cnt_d   = '0;
          end else if (win_last) begin
            err_cnt_d = mismatch ? ERR_W'(1) : '0;
          end else if (mismatch) begin
            err_cnt_d = err_inc;
          end
        end

        default: begin
          state_d = ST_UNLOCKED;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  assign rand_num = rand_num_q;
  assign locked   = locked_q;
  assign lock_err = lock_err_q;
  assign state    = state_q;

endmodule

// File: doc/stream_dscr_slv.md
Name: stream_dscr_slv

Overview:
- Receive-side side-stream descrambler synchroniser for the slave-generated scrambler stream, polynomial x^33 + x^20 + 1 (feedback = bit32 ^ bit19).
- Sits in the master-side PHY RX path, after symbol decode.
- Acquires the remote 33-bit LFSR state from recovered idle-symbol scrambler bits, verifies the prediction, and then free-runs in lock.
- Supplies the local descrambler state and a lock indication to the PCS RX.

Parameters:
- VERIFY_CNT, 64: consecutive idle matches required in VERIFY before lock (range 1..255).
- ERR_MAX, 4: idle mismatches within one window that force loss of lock (range 1..15).
- WIN_LEN, 256: error-window length in valid cycles while LOCKED (range 2..65535).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- load  input  1  synchronous re-acquire request, active high.
- valid  input  1  one recovered symbol this cycle.
- idle_ind  input  1  current symbol is idle, so rx_bit is meaningful.
- rx_bit  input  1  scrambler bit recovered from the idle symbol.
- rand_num  output  33  local LFSR state; bit0 = newest bit.
- locked  output  1  high while state is LOCKED.
- lock_err  output  1  one-cycle pulse on any idle mismatch in VERIFY or LOCKED.
- state  output  2  0=UNLOCKED, 1=VERIFY, 2=LOCKED.

Behaviour:
- Reset: rst_n low at a clk edge clears rand_num, locked, lock_err, state, and all internal counters. Reset is synchronous and active-low.
- Precedence:
  - rst_n has highest priority.
  - load comes next. It forces UNLOCKED and clears fill_cnt, match_cnt, err_cnt, win_cnt and lock_err. rand_num is held.
  - Normal operation follows.
- Cycles with valid=0: no state or register changes; lock_err deasserts.
- Prediction: pred = rand_num[32] ^ rand_num[19]. LFSR advance is rand_num <= {rand_num[31:0], pred}.
- UNLOCKED:
  - valid & idle_ind: rand_num <= {rand_num[31:0], rx_bit}; fill_cnt++.
  - valid & !idle_ind: fill_cnt <= 0. Acquisition requires 33 consecutive idle bits.
  - On the 33rd consecutive idle bit, go to VERIFY on the next cycle with match_cnt=0.
- VERIFY:
  - Every valid cycle: LFSR advances.
  - If idle_ind and pred==rx_bit: match_cnt++. When match_cnt reaches VERIFY_CNT, go to LOCKED; locked rises in the same registered update.
  - If idle_ind and pred!=rx_bit: lock_err pulse; go to UNLOCKED with fill_cnt=0.
  - Non-idle valid: LFSR advances, no compare, match_cnt unchanged.
- LOCKED:
  - Every valid cycle: LFSR advances and win_cnt++, wrapping at WIN_LEN-1 back to 0.
  - Idle mismatch: lock_err pulse; err_cnt++.
  - If err_cnt would reach ERR_MAX: go to UNLOCKED, locked falls, counters clear. This has priority over the window wrap.
  - Window wrap in the same cycle as a non-fatal mismatch: err_cnt <= 1.
  - Window wrap with no mismatch: err_cnt <= 0.
- Outputs: all registered; locked == (state==2).
- Latency: rand_num reflects a bit one cycle after its valid edge.
- Lock timing: with an error-free stream, lock asserts one cycle after the (33+VERIFY_CNT)th idle valid.

Optional Feature:
- Macro: DSCR_MASTER_POLY_EN.
- Defined: feedback tap changes to rand_num[32] ^ rand_num[12] (x^33 + x^13 + 1, master polynomial). The block can then descramble the master stream for loopback or slave-side reuse.
- Undefined: slave polynomial as above.
- Ports and state machine are identical in both builds.

Test Plan:
- Reset and idle:
  - Stimulus: rst_n=0 for 2 clk, then valid=0 for 10 clk.
  - Response: rand_num=0, state=0, locked=0, lock_err=0 throughout.
- Clean acquisition:
  - Stimulus: model slave LFSR seeded 33'h0_0000_0001; 200 idle valids of its output bit.
  - Response: state=1 after the 33rd; locked=1 one cycle after the 97th; rand_num equals model state every cycle thereafter; lock_err never asserts.
- Interrupted fill:
  - Stimulus: 20 idle bits, 1 non-idle valid, then 33 idle bits.
  - Response: VERIFY is entered only after the final 33rd idle bit, not at bit 33 overall.
- VERIFY mismatch:
  - Stimulus: lock sequence with rx_bit inverted on the 10th VERIFY idle.
  - Response: lock_err pulses one cycle; state returns to 0; re-acquisition then succeeds.
- Loss of lock:
  - Stimulus: while LOCKED, invert 4 idle bits within 100 valids.
  - Response: 4 lock_err pulses; locked falls after the 4th.
  - Stimulus: 3 inversions spread one per 256-cycle window.
  - Response: locked stays 1.
- load mid-lock:
  - Stimulus: assert load for 1 cycle while LOCKED and simultaneously valid with a mismatch.
  - Response: state=0 next cycle, locked=0, lock_err=0, rand_num unchanged.
